// File: rtl/vga_capture.sv
// VGA receive monitor: measures HS/VS timing, locks after clean frames, emits active-area pixels.
// All outputs registered, 1 cycle from sampled input; no backpressure, one pixel per clock.
module vga_capture #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       CLOCK_25,
    input  logic       RESET,
    input  logic       VGA_HS,
    input  logic       VGA_VS,
    input  logic [7:0] VGA_R,
    input  logic [7:0] VGA_G,
    input  logic [7:0] VGA_B,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic [7:0] pix_r,
    output logic [7:0] pix_g,
    output logic [7:0] pix_b,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       locked,
    output logic       timing_err,
    output logic [7:0] err_count
);

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam logic [9:0] HA0 = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] HA1 = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] VA0 = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] VA1 = 10'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] good_q, good_d, good_inc;
    logic          hs_q;
    logic          vs_line_q;
    logic [9:0]    hcnt_q, hcnt_d;
    logic [9:0]    vcnt_q, vcnt_d;
    logic [9:0]    pix_x_q, pix_y_q;
    logic [7:0]    pix_r_q, pix_g_q, pix_b_q;
    logic          pix_valid_q, frame_start_q, locked_q, timing_err_q;
    logic [7:0]    err_q;

    logic          hs_fall, frame_bnd, timeout;
    logic          line_bad, frame_bad, viol, active, valid_d;
    logic [10:0]   line_len, frame_len;

    assign hs_fall   = hs_q & ~VGA_HS;
    // vs_line_q holds VS as seen at the previous line start, so a frame
    // boundary is the first line start with VS low.
    assign frame_bnd = hs_fall & ~VGA_VS & vs_line_q;
    assign line_len  = {1'b0, hcnt_q} + 11'd1;
    assign frame_len = {1'b0, vcnt_q} + 11'd1;
    assign timeout   = ~hs_fall & (hcnt_q == 10'h3FE);
    assign line_bad  = hs_fall & (line_len != 11'(H_TOTAL));
    assign frame_bad = frame_bnd & (frame_len != 11'(V_TOTAL));
    assign viol      = timeout | ((state_q != SEARCH) & (line_bad | frame_bad));
    assign good_inc  = good_q + GW'(1);

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hs_fall) begin
            hcnt_d = 10'd0;
            if (frame_bnd) begin
                vcnt_d = 10'd0;
            end else if (vcnt_q != 10'h3FF) begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end else if (hcnt_q != 10'h3FF) begin
            hcnt_d = hcnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (frame_bnd) begin
                    state_d = CHECK;
                    good_d  = '0;
                end
            end
            CHECK: begin
                if (viol) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end else if (frame_bnd) begin
                    good_d = good_inc;
                    if (good_inc == GW'(LOCK_FRAMES)) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (viol) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    assign active  = (hcnt_d >= HA0) && (hcnt_d < HA1) && (vcnt_d >= VA0) && (vcnt_d < VA1);
    assign valid_d = (state_d == LOCKED) && active;

    always_ff @(posedge CLOCK_25) begin
        if (RESET) begin
            state_q       <= SEARCH;
            good_q        <= '0;
            hs_q          <= 1'b1;
            vs_line_q     <= 1'b1;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            pix_x_q       <= 10'd0;
            pix_y_q       <= 10'd0;
            pix_r_q       <= 8'd0;
            pix_g_q       <= 8'd0;
            pix_b_q       <= 8'd0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            err_q         <= 8'd0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            hs_q      <= VGA_HS;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            if (hs_fall) begin
                vs_line_q <= VGA_VS;
            end
            // Coordinates and colour hold their last value outside the active area.
            if (valid_d) begin
                pix_x_q <= hcnt_d - HA0;
                pix_y_q <= vcnt_d - VA0;
                pix_r_q <= VGA_R;
                pix_g_q <= VGA_G;
                pix_b_q <= VGA_B;
            end
            pix_valid_q   <= valid_d;
            frame_start_q <= valid_d && (hcnt_d == HA0) && (vcnt_d == VA0);
            locked_q      <= (state_d == LOCKED);
            timing_err_q  <= viol;
            if (viol && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'd1;
            end
        end
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign err_count   = err_q;

endmodule
